// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result path.
//   - Opcode encodings selecting one of the four logic units.
//   - Bit positions inside the packed {N,V,C} flag vectors produced by the units.
package alu_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_NOT = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    localparam int NVC_N = 2;
    localparam int NVC_V = 1;
    localparam int NVC_C = 0;

endpackage

// File: rtl/alu_pair_buffer.sv
// Generic 2-entry FIFO with valid/ready handshakes on both sides.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : write side; push when both high
//   in_data               : entry to write
//   out_valid/out_ready   : read side; pop when both high
//   out_data              : head entry (always driven from storage)
// Entry 0 is always the head, so out_data is a plain register output.
// After the last entry is popped the head keeps its old contents.
module alu_pair_buffer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [1:0]   count;
    logic [W-1:0] mem0;
    logic [W-1:0] mem1;
    logic         push;
    logic         pop;

    // Ready depends only on registered occupancy and reset, never on out_ready.
    assign in_ready  = !rst && (count < 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_data  = mem0;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 2'd0;
            mem0  <= '0;
            mem1  <= '0;
        end else begin
            case ({push, pop})
                2'b11: begin
                    // Only reachable with count == 1: head is replaced in place.
                    mem0 <= in_data;
                end
                2'b10: begin
                    if (count == 2'd0) mem0 <= in_data;
                    else               mem1 <= in_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    // Popping the last entry leaves the stale head in mem0.
                    if (count == 2'd2) mem0 <= mem1;
                    count <= count - 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// Registered result stage behind the four logic units.
//   clk, rst                         : clock, synchronous active-high reset
//   in_valid/in_ready, in_op         : operation handshake and unit select
//   *_res, *_nvc                     : unit results and {N,V,C} flags
//   out_valid/out_ready              : head handshake
//   out_res, out_N/Z/V/C             : head entry result and flags
//   op_cnt                           : accepted-operation counter (wraps)
//   zero_seen, clr_sticky            : sticky zero-result indicator and its clear
// Selects the chosen unit, derives Z, and queues {R,N,Z,V,C} in a 2-entry FIFO.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int bits     = 4,
    parameter int cnt_bits = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          in_op,
    input  logic [bits-1:0]     and_res,
    input  logic [bits-1:0]     or_res,
    input  logic [bits-1:0]     not_res,
    input  logic [bits-1:0]     xor_res,
    input  logic [2:0]          and_nvc,
    input  logic [2:0]          or_nvc,
    input  logic [2:0]          not_nvc,
    input  logic [2:0]          xor_nvc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [bits-1:0]     out_res,
    output logic                out_N,
    output logic                out_Z,
    output logic                out_V,
    output logic                out_C,
    output logic [cnt_bits-1:0] op_cnt,
    output logic                zero_seen,
    input  logic                clr_sticky
);

    localparam int W = bits + 4;

    logic [bits-1:0] sel_res;
    logic [2:0]      sel_nvc;
    logic            sel_z;
    logic [W-1:0]    push_data;
    logic [W-1:0]    head_data;
    logic            push;

    always_comb begin
        sel_res = and_res;
        sel_nvc = and_nvc;
        case (in_op)
            OP_AND: begin sel_res = and_res; sel_nvc = and_nvc; end
            OP_OR:  begin sel_res = or_res;  sel_nvc = or_nvc;  end
            OP_NOT: begin sel_res = not_res; sel_nvc = not_nvc; end
            OP_XOR: begin sel_res = xor_res; sel_nvc = xor_nvc; end
            default: ;
        endcase
    end

    assign sel_z     = (sel_res == '0);
    assign push_data = {sel_res, sel_nvc[NVC_N], sel_z, sel_nvc[NVC_V], sel_nvc[NVC_C]};
    assign push      = in_valid && in_ready;

    alu_pair_buffer #(.W(W)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (push_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head_data)
    );

    assign out_res = head_data[W-1:4];
    assign out_N   = head_data[3];
    assign out_Z   = head_data[2];
    assign out_V   = head_data[1];
    assign out_C   = head_data[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            op_cnt    <= '0;
            zero_seen <= 1'b0;
        end else begin
            if (push) op_cnt <= op_cnt + 1'b1;
            // A zero-result push in the same cycle as a clear keeps the flag set.
            if (push && sel_z)   zero_seen <= 1'b1;
            else if (clr_sticky) zero_seen <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_op;
    logic [3:0] and_res, or_res, not_res, xor_res;
    logic [2:0] and_nvc, or_nvc, not_nvc, xor_nvc;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_res;
    logic       out_N, out_Z, out_V, out_C;
    logic [7:0] op_cnt;
    logic       zero_seen;
    logic       clr_sticky;
    logic [3:0] flags;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign flags = {out_N, out_Z, out_V, out_C};

    alu_result_stage #(.bits(4), .cnt_bits(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .and_res(and_res), .or_res(or_res), .not_res(not_res), .xor_res(xor_res),
        .and_nvc(and_nvc), .or_nvc(or_nvc), .not_nvc(not_nvc), .xor_nvc(xor_nvc),
        .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
        .out_N(out_N), .out_Z(out_Z), .out_V(out_V), .out_C(out_C),
        .op_cnt(op_cnt), .zero_seen(zero_seen), .clr_sticky(clr_sticky)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; in_valid = 0; in_op = 2'b00; out_ready = 0; clr_sticky = 0;
        and_res = 4'b1000; or_res = 4'b0101; not_res = 4'b0011; xor_res = 4'b1111;
        and_nvc = 3'b100;  or_nvc = 3'b010;  not_nvc = 3'b001;  xor_nvc = 3'b000;
        step(); step();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_res", out_res, 0);
        chk("rst_flags", flags, 0);
        chk("rst_op_cnt", op_cnt, 0);
        chk("rst_zero_seen", zero_seen, 0);
        rst = 0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        // Single AND push, latency 1
        in_valid = 1; in_op = 2'b00; out_ready = 1;
        step();
        in_valid = 0;
        chk("t1_out_valid", out_valid, 1);
        chk("t1_out_res", out_res, 4'b1000);
        chk("t1_flags", flags, 4'b1000);
        chk("t1_op_cnt", op_cnt, 1);
        step();
        chk("t1_drained", out_valid, 0);

        // Fill to full with out_ready low; third push is refused
        out_ready = 0;
        in_valid = 1; in_op = 2'b01; step();
        in_op = 2'b10; step();
        chk("t2_full_in_ready", in_ready, 0);
        in_op = 2'b11; step();
        in_valid = 0;
        chk("t2_op_cnt", op_cnt, 3);
        chk("t2_head0_res", out_res, 4'b0101);
        chk("t2_head0_flags", flags, 4'b0010);
        out_ready = 1; step();
        chk("t2_head1_valid", out_valid, 1);
        chk("t2_head1_res", out_res, 4'b0011);
        chk("t2_head1_flags", flags, 4'b0001);
        chk("t2_ready_back", in_ready, 1);
        step();
        chk("t2_empty", out_valid, 0);
        out_ready = 0;

        // Simultaneous push/pop at count 1, zero XOR result
        and_res = 4'b0110; and_nvc = 3'b000;
        in_valid = 1; in_op = 2'b00; step();
        chk("t3_zero_before", zero_seen, 0);
        xor_res = 4'b0000; xor_nvc = 3'b011;
        in_op = 2'b11; out_ready = 1; step();
        in_valid = 0; out_ready = 0;
        chk("t3_out_valid", out_valid, 1);
        chk("t3_count1", in_ready, 1);
        chk("t3_res", out_res, 4'b0000);
        chk("t3_flags", flags, 4'b0111);
        chk("t3_zero_seen", zero_seen, 1);
        chk("t3_op_cnt", op_cnt, 5);
        out_ready = 1; step();
        chk("t3_drained", out_valid, 0);

        // Set beats clear; clear alone clears
        clr_sticky = 1; in_valid = 1; in_op = 2'b11; step();
        in_valid = 0;
        chk("t4_set_wins", zero_seen, 1);
        step();
        clr_sticky = 0;
        chk("t4_cleared", zero_seen, 0);
        chk("t4_op_cnt", op_cnt, 6);

        // Counter wrap: 250 more pushes from 6
        and_res = 4'b1001; and_nvc = 3'b000; in_op = 2'b00; in_valid = 1;
        repeat (249) step();
        chk("t5_op_cnt_255", op_cnt, 255);
        step();
        in_valid = 0;
        chk("t5_op_cnt_wrap", op_cnt, 0);
        chk("t5_no_zero", zero_seen, 0);
        step();
        chk("t5_drained", out_valid, 0);

        // Reset with full queue; input during reset ignored
        out_ready = 0; and_res = 4'b1000; in_valid = 1; step(); step();
        in_valid = 0;
        chk("t6_full", in_ready, 0);
        chk("t6_op_cnt", op_cnt, 2);
        rst = 1; in_valid = 1; step();
        chk("t6_rst_out_valid", out_valid, 0);
        chk("t6_rst_op_cnt", op_cnt, 0);
        chk("t6_rst_out_res", out_res, 0);
        chk("t6_rst_in_ready", in_ready, 0);
        step();
        rst = 0; in_valid = 0;
        #1;
        chk("t6_in_ready_back", in_ready, 1);
        step();
        chk("t6_still_empty", out_valid, 0);
        chk("t6_op_cnt_zero", op_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Registered output stage downstream of the four logic units (`compuerta_and`, `compuerta_or`, `compuerta_not`, `compuerta_xor`). It selects one unit's result and flags by opcode, derives the zero flag, and buffers the result in a 2-entry queue behind a valid/ready handshake. It also keeps an operation counter and a sticky zero indicator for the control sequencer.

## Interface
- `bits`, 4, datapath width; matches the `bits` of the logic units.
- `cnt_bits`, 8, width of the accepted-operation counter.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream presents an operation this cycle.
- `in_ready`  out  1  stage can accept; transfer occurs when `in_valid && in_ready`.
- `in_op`  in  2  unit select: 00 AND, 01 OR, 10 NOT, 11 XOR.
- `and_res`, `or_res`, `not_res`, `xor_res`  in  bits  unit result buses.
- `and_nvc`, `or_nvc`, `not_nvc`, `xor_nvc`  in  3  unit flags packed {N,V,C}.
- `out_valid`  out  1  head entry available.
- `out_ready`  in  1  downstream accepts; pop when `out_valid && out_ready`.
- `out_res`  out  bits  head entry result.
- `out_N`, `out_Z`, `out_V`, `out_C`  out  1 each  head entry flags.
- `op_cnt`  out  cnt_bits  number of accepted operations.
- `zero_seen`  out  1  sticky: some accepted operation produced a zero result.
- `clr_sticky`  in  1  clears `zero_seen`.

## Operation
- On push, capture the selected result R and flags {N,V,C} from the unit chosen by `in_op`. Set Z = (R == 0).
- N, V and C pass through unchanged from the unit. The stage does not recompute them.
- Queue depth is 2. `count` is in 0..2.
  - `in_ready = !rst && (count < 2)`.
  - `out_valid = (count != 0)`.
- Output ports always show the head entry. When `count == 0`, the head holds the last popped value or the reset zeros. Downstream must ignore it while `out_valid = 0`.
- Push and pop in the same cycle: `count` is unchanged and entries shift in order. At `count == 2`, no push is possible because `in_ready = 0`.
- Ordering is strict FIFO. No entry is dropped or duplicated.
- `op_cnt` increments by 1 on each push and wraps from 2^cnt_bits−1 to 0.
- `zero_seen` sets on a push with Z = 1. `clr_sticky` clears it. If both happen in the same cycle, set wins and the result is 1.
- `in_op` values are all legal. There is no error state.

## Timing
- Latency from a push to that entry on the outputs with `out_valid` asserted is 1 cycle when the queue was empty.
- `in_ready` depends only on registered `count` and `rst`. There is no combinational path from `out_ready` to `in_ready`. After a pop from full, `in_ready` returns on the next cycle.
- Outputs follow registered state only. There is no combinational path from any input to `out_*`.
- Reset values: `count = 0`, `out_valid = 0`, `in_ready = 0` while `rst` is high and 1 on the cycle after, `out_res = 0`, all `out_*` flags 0, `op_cnt = 0`, `zero_seen = 0`.
- A reset asserted mid-operation discards all queued entries. An input presented during `rst` is not accepted.

## Structure
- Shared package `alu_pkg`:
  - opcode constants `OP_AND=2'b00`, `OP_OR=2'b01`, `OP_NOT=2'b10`, `OP_XOR=2'b11`.
  - flag-vector index constants `NVC_N=2`, `NVC_V=1`, `NVC_C=0`.
- Sub-module `alu_pair_buffer`:
  - generic 2-entry FIFO of width `bits+4`, holding {R,N,Z,V,C}, with the valid/ready rules above.
- Top level holds the opcode mux, the Z derivation, `op_cnt` and `zero_seen`.

## Test plan
- Reset, then push op=00 with `and_res=4'b1000` and `and_nvc=3'b100` while `out_ready=1`. Next cycle: `out_valid=1`, `out_res=4'b1000`, N=1, Z=0, V=0, C=0. `op_cnt=1`.
- Hold `out_ready=0` and push 3 ops: the third sees `in_ready=0`. After 2 pops, entries emerge in order and `count` returns to 0.
- With `count=1`, push op=11 (`xor_res=4'b0000`) and pop in the same cycle. `count` stays 1, the new head has Z=1, and `zero_seen=1`.
- Assert `clr_sticky` in the same cycle as a zero-result push: `zero_seen` stays 1. Assert `clr_sticky` alone: `zero_seen` goes to 0.
- Push 256 ops: `op_cnt` wraps to 0.
- Assert `rst` with the queue full: next cycle `out_valid=0`, `op_cnt=0`, `out_res=0`, and `in_ready=1` once `rst` is low.
